conv_1x1_pe_array: RTL

- Parametrised successor of the single-output 1x1 conv PE.
- Consumes CIN_PAR input-channel bytes per beat and produces COUT_PAR output channels in parallel, all sharing the same pixel word.
- Accumulates across beats until last_channel, then adds per-lane bias.
- Adds valid/ready backpressure, selectable pixel signedness and an optional leaky-ReLU output stage.
- Sits between the line-buffer/pixel feeder and the requant/writeback stage.

---
 rtl/conv_pe_pkg.sv | 24 ++
 rtl/conv_dot_lane.sv | 56 +++++
 rtl/conv_1x1_pe_array.sv | 100 ++++++++++
 3 files changed

// File: rtl/conv_pe_pkg.sv
// conv_pe_pkg: shared default widths and width/activation helpers
// for the parallel 1x1 convolution PE array.
package conv_pe_pkg;

   localparam int DEF_DW    = 8;
   localparam int DEF_WW    = 8;
   localparam int DEF_ACC_W = 32;

   // Unsigned pixels get a zero sign bit, hence the extra product bit.
   function automatic int prod_w(int dw, int ww, bit sgn);
      return sgn ? (dw + ww) : (dw + ww + 1);
   endfunction

   function automatic int sum_w(int pw, int n);
      return pw + $clog2(n);
   endfunction

   function automatic logic signed [DEF_ACC_W-1:0] leaky_relu(
      logic signed [DEF_ACC_W-1:0] y
   );
      return y[DEF_ACC_W-1] ? (y >>> 3) : y;
   endfunction

endpackage

// File: rtl/conv_dot_lane.sv
// conv_dot_lane: one output lane of the PE array, CIN_PAR multipliers
// (stage 0) feeding a registered signed reduction sum (stage 1).
module conv_dot_lane
   import conv_pe_pkg::*;
#(
   parameter int CIN_PAR      = 8,
   parameter int DW           = DEF_DW,
   parameter int WW           = DEF_WW,
   parameter bit PIXEL_SIGNED = 1'b0,
   localparam int PW = prod_w(DW, WW, PIXEL_SIGNED),
   localparam int SW = sum_w(PW, CIN_PAR)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [CIN_PAR*DW-1:0]   pixel,
   input  logic [CIN_PAR*WW-1:0]   weights,
   output logic signed [SW-1:0]    sum
);

   localparam int FW = DW + WW + 1;

   logic signed [PW-1:0] prod_d [CIN_PAR];
   logic signed [PW-1:0] prod_q [CIN_PAR];
   logic signed [SW-1:0] sum_d;

   for (genvar j = 0; j < CIN_PAR; j++) begin : g_mul
      logic signed [DW:0]   px;
      logic signed [WW-1:0] w;
      logic signed [FW-1:0] p;
      assign px = PIXEL_SIGNED ? {pixel[j*DW+DW-1], pixel[j*DW +: DW]}
                               : {1'b0, pixel[j*DW +: DW]};
      assign w  = weights[j*WW +: WW];
      assign p  = FW'(px) * FW'(w);
      // Signed-by-signed products fit in DW+WW bits, so this only drops copies of the sign.
      assign prod_d[j] = p[PW-1:0];
   end

   always_comb begin
      sum_d = '0;
      for (int j = 0; j < CIN_PAR; j++) begin
         sum_d = sum_d + SW'(prod_q[j]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '{default: '0};
         sum    <= '0;
      end else if (en) begin
         prod_q <= prod_d;
         sum    <= sum_d;
      end
   end

endmodule

// File: rtl/conv_1x1_pe_array.sv
// conv_1x1_pe_array: COUT_PAR-lane 1x1 conv PE with valid/ready backpressure.
// Optional leaky-ReLU output stage: define CONV1X1_PE_LEAKY_RELU_EN.
module conv_1x1_pe_array
   import conv_pe_pkg::*;
#(
   parameter int CIN_PAR      = 8,
   parameter int COUT_PAR     = 4,
   parameter int DW           = DEF_DW,
   parameter int WW           = DEF_WW,
   parameter int ACC_W        = DEF_ACC_W,
   parameter bit PIXEL_SIGNED = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         last_channel,
   input  logic [CIN_PAR*DW-1:0]        pixel,
   input  logic [COUT_PAR*CIN_PAR*WW-1:0] weights,
   input  logic [COUT_PAR*ACC_W-1:0]    bias,
   output logic [COUT_PAR*ACC_W-1:0]    out_data,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int PW = prod_w(DW, WW, PIXEL_SIGNED);
   localparam int SW = sum_w(PW, CIN_PAR);

   logic                        en;
   logic                        v0, l0, v1, l1;
   logic [COUT_PAR*ACC_W-1:0]   b0, b1;
   logic signed [SW-1:0]        lane_sum [COUT_PAR];
   logic signed [ACC_W-1:0]     acc      [COUT_PAR];
   logic signed [ACC_W-1:0]     acc_nx   [COUT_PAR];
   logic signed [ACC_W-1:0]     y_raw    [COUT_PAR];
   logic signed [ACC_W-1:0]     y        [COUT_PAR];

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < COUT_PAR; k++) begin : g_lane
      conv_dot_lane #(
         .CIN_PAR      (CIN_PAR),
         .DW           (DW),
         .WW           (WW),
         .PIXEL_SIGNED (PIXEL_SIGNED)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en),
         .pixel   (pixel),
         .weights (weights[k*CIN_PAR*WW +: CIN_PAR*WW]),
         .sum     (lane_sum[k])
      );
   end

   always_comb begin
      for (int k = 0; k < COUT_PAR; k++) begin
         acc_nx[k] = acc[k] + ACC_W'(lane_sum[k]);
         y_raw[k]  = acc_nx[k] + $signed(b1[k*ACC_W +: ACC_W]);
`ifdef CONV1X1_PE_LEAKY_RELU_EN
         // Helper is DEF_ACC_W wide; exact for any ACC_W up to that width.
         y[k] = ACC_W'(leaky_relu(DEF_ACC_W'(y_raw[k])));
`else
         y[k] = y_raw[k];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0        <= 1'b0;
         l0        <= 1'b0;
         b0        <= '0;
         v1        <= 1'b0;
         l1        <= 1'b0;
         b1        <= '0;
         acc       <= '{default: '0};
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (en) begin
         v0 <= in_valid;
         l0 <= in_valid && last_channel;
         if (in_valid && last_channel) b0 <= bias;
         v1        <= v0;
         l1        <= l0;
         b1        <= b0;
         out_valid <= v1 && l1;
         for (int k = 0; k < COUT_PAR; k++) begin
            if (v1 && l1) begin
               out_data[k*ACC_W +: ACC_W] <= y[k];
               acc[k]                     <= '0;
            end else if (v1) begin
               acc[k] <= acc_nx[k];
            end
         end
      end
   end

endmodule
